// File: rtl/umni_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encoding,
// BCD digit constants and default sizing.
package umni_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam int BCD_DIGIT_W = 4;
    localparam int ADD3_THRESH = 5;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DIGITS  = 3;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Single BCD digit corrector for the shift-and-add-3 algorithm:
// a digit of 5 or more gets 3 added before the next left shift.
module bcd_add3
    import umni_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= BCD_DIGIT_W'(ADD3_THRESH))
                   ? digit_i + BCD_DIGIT_W'(3)
                   : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, with a
// start/busy/done handshake and a result register held between conversions.
module bin_to_bcd_seq
    import umni_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [WIDTH-1:0]            bin,
    output logic                        busy,
    output logic                        done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               busy_q;
    logic               done_q;
    logic [BCD_W-1:0]   corr;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_add3 u_add3 (
                .digit_i (scratch_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_o (corr[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(WIDTH);
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Correct every digit, then shift the combined register left.
                {scratch_d, shift_d} = {corr[BCD_W-2:0], shift_q, 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d   = scratch_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_q == S_DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule
